sap1_controller: RTL and testbench

SAP1_CONTROLLER -- requirements
Module: sap1_controller

---
 rtl/sap1_controller.sv | 152 +++++++++++++++
 tb/tb_sap1_controller.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sap1_controller.sv
// sap1_controller: SAP-1 one-hot T1..T6 ring counter with combinational control-word decode.
// Optional macro SAP1_CTRL_EARLY_END_EN returns to T1 after each instruction's last active state. Rev 1.0
`default_nettype none

module sap1_controller #(
  parameter logic [3:0] OPC_LDA = 4'h0,
  parameter logic [3:0] OPC_ADD = 4'h1,
  parameter logic [3:0] OPC_SUB = 4'h2,
  parameter logic [3:0] OPC_OUT = 4'hE,
  parameter logic [3:0] OPC_HLT = 4'hF
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [3:0] opcode,
  output logic       Cp,
  output logic       Ep,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       Lm_n,
  output logic       Ce_n,
  output logic       Li_n,
  output logic       Ei_n,
  output logic       La_n,
  output logic       Lb_n,
  output logic       Lo_n,
  output logic       hlt,
  output logic [5:0] tstate
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_t;

  tstate_t state;
  tstate_t state_next;

  logic is_lda;
  logic is_add;
  logic is_sub;
  logic is_out;
  logic is_hlt;

  assign is_lda = (opcode == OPC_LDA);
  assign is_add = (opcode == OPC_ADD);
  assign is_sub = (opcode == OPC_SUB);
  assign is_out = (opcode == OPC_OUT);
  assign is_hlt = (opcode == OPC_HLT);

`ifdef SAP1_CTRL_EARLY_END_EN
  logic is_nop;
  assign is_nop = !(is_lda || is_add || is_sub || is_out || is_hlt);
`endif

  assign tstate = state;

  always_comb begin
    state_next = T1;
    case (state)
      T1: state_next = T2;
      T2: state_next = T3;
`ifdef SAP1_CTRL_EARLY_END_EN
      T3: state_next = is_nop ? T1 : T4;
      T4: state_next = is_out ? T1 : T5;
      T5: state_next = is_lda ? T1 : T6;
`else
      T3: state_next = T4;
      T4: state_next = T5;
      T5: state_next = T6;
`endif
      T6: state_next = T1;
      default: state_next = T1;
    endcase
  end

  // Halt latches on the edge leaving T4 and freezes the ring at T5 until clear.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= T1;
      hlt   <= 1'b0;
    end else if (!hlt) begin
      if (state == T4 && is_hlt) begin
        hlt   <= 1'b1;
        state <= T5;
      end else begin
        state <= state_next;
      end
    end
  end

  always_comb begin
    Cp   = 1'b0;
    Ep   = 1'b0;
    Ea   = 1'b0;
    Su   = 1'b0;
    Eu   = 1'b0;
    Lm_n = 1'b1;
    Ce_n = 1'b1;
    Li_n = 1'b1;
    Ei_n = 1'b1;
    La_n = 1'b1;
    Lb_n = 1'b1;
    Lo_n = 1'b1;
    if (!hlt) begin
      case (state)
        T1: begin
          Ep   = 1'b1;
          Lm_n = 1'b0;
        end
        T2: Cp = 1'b1;
        T3: begin
          Ce_n = 1'b0;
          Li_n = 1'b0;
        end
        T4: begin
          if (is_lda || is_add || is_sub) begin
            Ei_n = 1'b0;
            Lm_n = 1'b0;
          end else if (is_out) begin
            Ea   = 1'b1;
            Lo_n = 1'b0;
          end
        end
        T5: begin
          if (is_lda) begin
            Ce_n = 1'b0;
            La_n = 1'b0;
          end else if (is_add || is_sub) begin
            Ce_n = 1'b0;
            Lb_n = 1'b0;
          end
        end
        T6: begin
          if (!is_lda && (is_add || is_sub)) begin
            Eu   = 1'b1;
            La_n = 1'b0;
            Su   = is_sub && !is_add;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sap1_controller.sv
// tb_sap1_controller: directed checks of ring sequencing, control decode, halt and async clear.
`default_nettype none

module tb_sap1_controller;

  logic       clk;
  logic       clr_n;
  logic [3:0] opcode;
  logic       Cp, Ep, Ea, Su, Eu;
  logic       Lm_n, Ce_n, Li_n, Ei_n, La_n, Lb_n, Lo_n;
  logic       hlt;
  logic [5:0] tstate;
  logic [11:0] ctrl;

  int errors = 0;
  int checks = 0;

  // Control word order: {Cp,Ep,Ea,Su,Eu, Lm_n,Ce_n,Li_n,Ei_n,La_n,Lb_n,Lo_n}
  localparam logic [11:0] W_IDLE   = 12'b00000_1111111;
  localparam logic [11:0] W_T1     = 12'b01000_0111111;
  localparam logic [11:0] W_T2     = 12'b10000_1111111;
  localparam logic [11:0] W_T3     = 12'b00000_1001111;
  localparam logic [11:0] W_MEM_T4 = 12'b00000_0110111;
  localparam logic [11:0] W_LDA_T5 = 12'b00000_1011011;
  localparam logic [11:0] W_ADD_T5 = 12'b00000_1011101;
  localparam logic [11:0] W_ADD_T6 = 12'b00001_1111011;
  localparam logic [11:0] W_SUB_T6 = 12'b00011_1111011;
  localparam logic [11:0] W_OUT_T4 = 12'b00100_1111110;

  assign ctrl = {Cp, Ep, Ea, Su, Eu, Lm_n, Ce_n, Li_n, Ei_n, La_n, Lb_n, Lo_n};

  sap1_controller dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .opcode (opcode),
    .Cp     (Cp),
    .Ep     (Ep),
    .Ea     (Ea),
    .Su     (Su),
    .Eu     (Eu),
    .Lm_n   (Lm_n),
    .Ce_n   (Ce_n),
    .Li_n   (Li_n),
    .Ei_n   (Ei_n),
    .La_n   (La_n),
    .Lb_n   (Lb_n),
    .Lo_n   (Lo_n),
    .hlt    (hlt),
    .tstate (tstate)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [5:0] ts, input logic [11:0] w);
    chk({tag, ".tstate"}, {6'd0, tstate}, {6'd0, ts});
    chk({tag, ".ctrl"}, ctrl, w);
  endtask

  task automatic chk_bus(input string tag);
    int n;
    n = int'(Ep) + int'(!Ce_n) + int'(!Ei_n) + int'(Ea) + int'(Eu);
    checks++;
    assert (n <= 1) else begin
      errors++;
      $error("FAIL %s bus drivers observed=%0d expected<=1", tag, n);
    end
  endtask

  initial begin
    clr_n  = 1'b0;
    opcode = 4'h0;
    #12;
    chk_state("reset", 6'h01, W_T1);
    chk("reset.hlt", {11'd0, hlt}, 12'd0);
    tick();
    chk_state("reset_held_clk", 6'h01, W_T1);

    // LDA sequence from release
    clr_n = 1'b1;
    tick(); chk_state("lda_t2", 6'h02, W_T2);
    tick(); chk_state("lda_t3", 6'h04, W_T3);
    tick(); chk_state("lda_t4", 6'h08, W_MEM_T4);
    tick(); chk_state("lda_t5", 6'h10, W_LDA_T5);
`ifndef SAP1_CTRL_EARLY_END_EN
    tick(); chk_state("lda_t6", 6'h20, W_IDLE);
`endif
    tick(); chk_state("lda_wrap", 6'h01, W_T1);

    // SUB, with a combinational opcode swap at T6
    opcode = 4'h2;
    tick(); chk_state("sub_t2", 6'h02, W_T2);
    tick(); chk_state("sub_t3", 6'h04, W_T3);
    tick(); chk_state("sub_t4", 6'h08, W_MEM_T4);
    tick(); chk_state("sub_t5", 6'h10, W_ADD_T5);
    tick(); chk_state("sub_t6", 6'h20, W_SUB_T6);
    opcode = 4'h1;
    #1; chk_state("add_t6_comb", 6'h20, W_ADD_T6);
    opcode = 4'h2;
    #1; chk_state("sub_t6_back", 6'h20, W_SUB_T6);
    tick(); chk_state("sub_wrap", 6'h01, W_T1);

    // HLT freezes at T5
    opcode = 4'hF;
    tick(); tick(); tick();
    chk_state("hlt_t4", 6'h08, W_IDLE);
    chk("hlt_t4.hlt", {11'd0, hlt}, 12'd0);
    for (int i = 0; i < 10; i++) tick();
    chk_state("hlt_frozen", 6'h10, W_IDLE);
    chk("hlt_frozen.hlt", {11'd0, hlt}, 12'd1);
    #2 clr_n = 1'b0;
    #1;
    chk_state("hlt_clear", 6'h01, W_T1);
    chk("hlt_clear.hlt", {11'd0, hlt}, 12'd0);
    #1 clr_n = 1'b1;

    // ADD interrupted by clear mid-T5
    opcode = 4'h1;
    tick(); chk_state("add_t2", 6'h02, W_T2);
    tick(); tick();
    tick(); chk_state("add_t5", 6'h10, W_ADD_T5);
    #3 clr_n = 1'b0;
    #1 chk_state("add_t5_clear", 6'h01, W_T1);
    #1 clr_n = 1'b1;

    // OUT
    opcode = 4'hE;
    tick(); chk_state("out_t2", 6'h02, W_T2);
    tick(); chk_state("out_t3", 6'h04, W_T3);
    tick(); chk_state("out_t4", 6'h08, W_OUT_T4);
`ifndef SAP1_CTRL_EARLY_END_EN
    tick(); chk_state("out_t5", 6'h10, W_IDLE);
    tick(); chk_state("out_t6", 6'h20, W_IDLE);
`endif
    tick(); chk_state("out_wrap", 6'h01, W_T1);

    // Undefined opcode acts as NOP
    opcode = 4'h7;
    tick(); chk_state("nop_t2", 6'h02, W_T2);
    tick(); chk_state("nop_t3", 6'h04, W_T3);
`ifndef SAP1_CTRL_EARLY_END_EN
    tick(); chk_state("nop_t4", 6'h08, W_IDLE);
    tick(); chk_state("nop_t5", 6'h10, W_IDLE);
    tick(); chk_state("nop_t6", 6'h20, W_IDLE);
`endif
    tick(); chk_state("nop_wrap", 6'h01, W_T1);

    // Bus-driver exclusivity for every opcode across a full instruction
    for (int op = 0; op < 16; op++) begin
      opcode = op[3:0];
      clr_n = 1'b0;
      #1 clr_n = 1'b1;
      chk_bus($sformatf("bus_op%0h_t1", op));
      for (int s = 0; s < 6; s++) begin
        tick();
        chk_bus($sformatf("bus_op%0h_s%0d", op, s));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
